// File: rtl/uart_program_loader.sv
// uart_program_loader: serial boot loader feeding CPU program memory.
// Receives an 8N1 framed image, writes 16-bit words, gates CPU reset.
//
// Ports:
//   clk, rst           system clock, async active-high reset
//   rx                 UART RX line (idle high, async to clk)
//   progWriteEnable    one-cycle program memory write strobe
//   progWriteAddr      program memory word address
//   progWriteData      program word {hi, lo}
//   cpuRst             CPU reset, released only after a verified image
//   busy               frame in progress
//   loadDone           sticky: last frame verified
//   loadError          sticky: last frame aborted or bad checksum
module uart_program_loader #(
    parameter int ClksPerBit  = 234,
    parameter int AddrWidth   = 8,
    parameter int TimeoutClks = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 progWriteEnable,
    output logic [AddrWidth-1:0] progWriteAddr,
    output logic [15:0]          progWriteData,
    output logic                 cpuRst,
    output logic                 busy,
    output logic                 loadDone,
    output logic                 loadError
);

    localparam int BitCntW = $clog2(ClksPerBit + 1);
    localparam int HalfBit = (ClksPerBit / 2 > 0) ? ClksPerBit / 2 : 1;
    localparam int ToCntW  = $clog2(TimeoutClks + 1);
    localparam int CntW    = ((AddrWidth > 8) ? AddrWidth : 8) + 1;
    localparam logic [7:0] SyncByte = 8'hA5;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rxState_t;

    typedef enum logic [2:0] {
        Idle,
        Len,
        Hi,
        Lo,
        Chk
    } state_t;

    // ---------------- RX synchronizer ----------------
    logic rxMeta;
    logic rxSync;
    logic rxPrev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    // ---------------- UART byte receiver ----------------
    rxState_t           rxState;
    logic [BitCntW-1:0] bitClk;
    logic [2:0]         bitIdx;
    logic [7:0]         rxByte;
    logic               byteValid;
    logic               frameErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxState   <= RxIdle;
            bitClk    <= '0;
            bitIdx    <= '0;
            rxByte    <= '0;
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
            case (rxState)
                RxIdle: begin
                    bitClk <= '0;
                    bitIdx <= '0;
                    if (rxPrev && !rxSync) begin
                        rxState <= RxStart;
                    end
                end
                RxStart: begin
                    if (bitClk == BitCntW'(HalfBit - 1)) begin
                        bitClk  <= '0;
                        // a start bit that is gone by mid-bit was a glitch
                        rxState <= rxSync ? RxIdle : RxData;
                    end else begin
                        bitClk <= bitClk + BitCntW'(1);
                    end
                end
                RxData: begin
                    if (bitClk == BitCntW'(ClksPerBit - 1)) begin
                        bitClk <= '0;
                        rxByte <= {rxSync, rxByte[7:1]};
                        bitIdx <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
                            rxState <= RxStop;
                        end
                    end else begin
                        bitClk <= bitClk + BitCntW'(1);
                    end
                end
                RxStop: begin
                    if (bitClk == BitCntW'(ClksPerBit - 1)) begin
                        bitClk    <= '0;
                        byteValid <= rxSync;
                        frameErr  <= !rxSync;
                        rxState   <= RxIdle;
                    end else begin
                        bitClk <= bitClk + BitCntW'(1);
                    end
                end
                default: rxState <= RxIdle;
            endcase
        end
    end

    // ---------------- Frame FSM ----------------
    state_t               state;
    logic [AddrWidth-1:0] wordAddr;
    logic [CntW-1:0]      wordCnt;
    logic [7:0]           hiByte;
    logic [7:0]           xorAcc;
    logic [ToCntW-1:0]    toCnt;
    logic                 timedOut;

    assign timedOut = !byteValid && (toCnt == ToCntW'(TimeoutClks - 1));
    assign busy     = (state != Idle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= Idle;
            cpuRst          <= 1'b1;
            progWriteEnable <= 1'b0;
            progWriteAddr   <= '0;
            progWriteData   <= '0;
            loadDone        <= 1'b0;
            loadError       <= 1'b0;
            wordAddr        <= '0;
            wordCnt         <= '0;
            hiByte          <= '0;
            xorAcc          <= '0;
            toCnt           <= '0;
        end else begin
            progWriteEnable <= 1'b0;

            if (state == Idle || byteValid) begin
                toCnt <= '0;
            end else begin
                toCnt <= toCnt + ToCntW'(1);
            end

            if (state != Idle && (frameErr || timedOut)) begin
                loadError <= 1'b1;
                cpuRst    <= 1'b1;
                state     <= Idle;
            end else if (byteValid) begin
                case (state)
                    Idle: begin
                        if (rxByte == SyncByte) begin
                            cpuRst    <= 1'b1;
                            loadDone  <= 1'b0;
                            loadError <= 1'b0;
                            wordAddr  <= '0;
                            xorAcc    <= '0;
                            state     <= Len;
                        end
                    end
                    Len: begin
                        // zero length encodes a full memory image
                        if (rxByte == 8'h00) begin
                            wordCnt <= CntW'(1) << AddrWidth;
                        end else begin
                            wordCnt <= CntW'(rxByte);
                        end
                        xorAcc <= xorAcc ^ rxByte;
                        state  <= Hi;
                    end
                    Hi: begin
                        hiByte <= rxByte;
                        xorAcc <= xorAcc ^ rxByte;
                        state  <= Lo;
                    end
                    Lo: begin
                        progWriteEnable <= 1'b1;
                        progWriteAddr   <= wordAddr;
                        progWriteData   <= {hiByte, rxByte};
                        wordAddr        <= wordAddr + AddrWidth'(1);
                        xorAcc          <= xorAcc ^ rxByte;
                        wordCnt         <= wordCnt - CntW'(1);
                        state <= (wordCnt == CntW'(1)) ? Chk : Hi;
                    end
                    Chk: begin
                        if (rxByte == xorAcc) begin
                            loadDone <= 1'b1;
                            cpuRst   <= 1'b0;
                        end else begin
                            loadError <= 1'b1;
                        end
                        state <= Idle;
                    end
                    default: state <= Idle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed bench for the UART program loader.
// Scoreboard queue holds expected memory writes, checked on each strobe.
module tb_uart_program_loader;

    localparam int CPB = 8;
    localparam int AW  = 8;
    localparam int TO  = 400;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          progWriteEnable;
    logic [AW-1:0] progWriteAddr;
    logic [15:0]   progWriteData;
    logic          cpuRst;
    logic          busy;
    logic          loadDone;
    logic          loadError;

    int errors = 0;
    int checks = 0;
    logic [AW+15:0] expQ[$];

    uart_program_loader #(
        .ClksPerBit (CPB),
        .AddrWidth  (AW),
        .TimeoutClks(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx             (rx),
        .progWriteEnable(progWriteEnable),
        .progWriteAddr  (progWriteAddr),
        .progWriteData  (progWriteData),
        .cpuRst         (cpuRst),
        .busy           (busy),
        .loadDone       (loadDone),
        .loadError      (loadError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [AW+15:0] e;
        if (!rst && progWriteEnable) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", {31'b0, progWriteEnable}, 32'd0);
            end else begin
                e = expQ.pop_front();
                check("write", {8'h0, progWriteAddr, progWriteData},
                      {8'h0, e});
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input logic stopBit = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stopBit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic sendBody(input logic [7:0] len, input logic [15:0] w[$],
                            input logic corrupt);
        logic [7:0] chk;
        chk = len;
        sendByte(len);
        for (int i = 0; i < w.size(); i++) begin
            sendByte(w[i][15:8]);
            expQ.push_back({AW'(i), w[i]});
            sendByte(w[i][7:0]);
            chk = chk ^ w[i][15:8] ^ w[i][7:0];
        end
        sendByte(corrupt ? (chk ^ 8'h01) : chk);
    endtask

    task automatic checkResetVals(input string tag);
        check({tag, "_cpuRst"}, {31'b0, cpuRst}, 32'd1);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_loadDone"}, {31'b0, loadDone}, 32'd0);
        check({tag, "_loadError"}, {31'b0, loadError}, 32'd0);
        check({tag, "_we"}, {31'b0, progWriteEnable}, 32'd0);
        check({tag, "_addr"}, {24'b0, progWriteAddr}, 32'd0);
        check({tag, "_data"}, {16'b0, progWriteData}, 32'd0);
    endtask

    initial begin
        logic [15:0] w[$];

        // reset state
        repeat (3) @(negedge clk);
        checkResetVals("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkResetVals("post_reset");

        // good two-word frame
        w = '{16'h1234, 16'hABCD};
        sendByte(8'hA5);
        sendBody(8'h02, w, 1'b0);
        check("A_loadDone", {31'b0, loadDone}, 32'd1);
        check("A_loadError", {31'b0, loadError}, 32'd0);
        check("A_cpuRst", {31'b0, cpuRst}, 32'd0);
        check("A_busy", {31'b0, busy}, 32'd0);
        check("A_qempty", expQ.size(), 32'd0);

        // reload with bad checksum; A5 re-asserts cpuRst
        sendByte(8'hA5);
        check("B_cpuRst_after_sync", {31'b0, cpuRst}, 32'd1);
        check("B_loadDone_cleared", {31'b0, loadDone}, 32'd0);
        check("B_busy", {31'b0, busy}, 32'd1);
        sendBody(8'h02, w, 1'b1);
        check("B_loadError", {31'b0, loadError}, 32'd1);
        check("B_loadDone", {31'b0, loadDone}, 32'd0);
        check("B_cpuRst", {31'b0, cpuRst}, 32'd1);
        check("B_qempty", expQ.size(), 32'd0);

        // line glitch and junk bytes before a frame
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'h5A);
        check("C_junk_idle", {31'b0, busy}, 32'd0);
        w = '{16'h0007};
        sendByte(8'hA5);
        sendBody(8'h01, w, 1'b0);
        check("C_loadDone", {31'b0, loadDone}, 32'd1);
        check("C_cpuRst", {31'b0, cpuRst}, 32'd0);
        check("C_qempty", expQ.size(), 32'd0);

        // full image, LEN=0
        w = {};
        for (int i = 0; i < (1 << AW); i++) w.push_back(16'(i));
        sendByte(8'hA5);
        sendBody(8'h00, w, 1'b0);
        check("D_loadDone", {31'b0, loadDone}, 32'd1);
        check("D_loadError", {31'b0, loadError}, 32'd0);
        check("D_lastAddr", {24'b0, progWriteAddr}, 32'((1 << AW) - 1));
        check("D_qempty", expQ.size(), 32'd0);
        repeat (50) @(negedge clk);
        check("D_busy", {31'b0, busy}, 32'd0);

        // framing error mid-frame
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h12);
        sendByte(8'h34, 1'b0);
        check("E_loadError", {31'b0, loadError}, 32'd1);
        check("E_busy", {31'b0, busy}, 32'd0);
        check("E_cpuRst", {31'b0, cpuRst}, 32'd1);
        check("E_loadDone", {31'b0, loadDone}, 32'd0);

        // timeout after LEN
        sendByte(8'hA5);
        sendByte(8'h03);
        check("F_busy_before", {31'b0, busy}, 32'd1);
        check("F_noerr_before", {31'b0, loadError}, 32'd0);
        repeat (TO + 50) @(negedge clk);
        check("F_loadError", {31'b0, loadError}, 32'd1);
        check("F_busy", {31'b0, busy}, 32'd0);
        check("F_cpuRst", {31'b0, cpuRst}, 32'd1);

        // reset pulse mid-frame
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h12);
        check("G_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkResetVals("G_rst");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkResetVals("G_after");
        check("G_qempty", expQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
